// File: rtl/wb_stage.sv
// Writeback stage: selects ALU/load/PC+4/CSR result and drives the register-file write port.
// Latency: 1 cycle for non-loads; loads wait in WAIT_MEM for dmem_rvalid, then 1 cycle.
// Backpressure: mw_ready is low while a load is outstanding. Optional forwarding port is enabled by macro WB_FWD_EN.
module wb_stage #(
  parameter int XLEN         = 32,
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mw_valid,
  output logic            mw_ready,
  input  logic            mw_reg_wr,
  input  logic [4:0]      mw_rd,
  input  logic [1:0]      mw_wb_sel,
  input  logic [XLEN-1:0] mw_alu_result,
  input  logic [XLEN-1:0] mw_pc4,
  input  logic [XLEN-1:0] mw_csr_rdata,
  input  logic [2:0]      mw_ld_funct3,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            reg_wr,
  output logic [4:0]      write_add,
  output logic [XLEN-1:0] write_data,
  output logic            load_err,
  output logic            busy,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_LOAD = 2'd1;
  localparam logic [1:0] SEL_PC4  = 2'd2;
  localparam logic [1:0] SEL_CSR  = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Last counter value before the load is abandoned.
  localparam logic [7:0] TMO_LAST = 8'(LOAD_TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [7:0]      tmo_cnt, tmo_cnt_nxt;

  // Fields of the outstanding load, captured at accept.
  logic [4:0]      ld_rd;
  logic            ld_reg_wr;
  logic [2:0]      ld_funct3;
  logic [1:0]      ld_off;

  logic            accept;
  logic            is_load;
  logic            misalign;
  logic [XLEN-1:0] src_data;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_ext;

  logic            reg_wr_nxt;
  logic            load_err_nxt;
  logic [4:0]      write_add_nxt;
  logic [XLEN-1:0] write_data_nxt;

  assign mw_ready = (state == IDLE);
  assign busy     = (state == WAIT_MEM);
  assign accept   = mw_valid & mw_ready;
  assign is_load  = (mw_wb_sel == SEL_LOAD);

  // Non-load source select; LOAD never reaches this path.
  always_comb begin
    src_data = mw_alu_result;
    case (mw_wb_sel)
      SEL_PC4: src_data = mw_pc4;
      SEL_CSR: src_data = mw_csr_rdata;
      default: src_data = mw_alu_result;
    endcase
  end

  // Alignment check on the incoming load; undefined funct3 behaves like LW.
  always_comb begin
    misalign = 1'b0;
    case (mw_ld_funct3)
      F3_LB, F3_LBU: misalign = 1'b0;
      F3_LH, F3_LHU: misalign = mw_alu_result[0];
      default:       misalign = (mw_alu_result[1:0] != 2'b00);
    endcase
  end

  // Little-endian byte/half extraction and sign/zero extension of returned data.
  always_comb begin
    ld_byte = dmem_rdata[{ld_off, 3'b000} +: 8];
    ld_half = dmem_rdata[{ld_off[1], 4'b0000} +: 16];
    ld_ext  = dmem_rdata;
    case (ld_funct3)
      F3_LB:   ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_LBU:  ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
      F3_LH:   ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
      F3_LHU:  ld_ext = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  // Next-state and next-output logic; write_add/write_data hold unless a result retires.
  always_comb begin
    state_nxt      = state;
    tmo_cnt_nxt    = tmo_cnt;
    reg_wr_nxt     = 1'b0;
    load_err_nxt   = 1'b0;
    write_add_nxt  = write_add;
    write_data_nxt = write_data;
    case (state)
      IDLE: begin
        if (mw_valid) begin
          if (is_load) begin
            if (misalign) begin
              load_err_nxt = 1'b1;
            end else begin
              state_nxt   = WAIT_MEM;
              tmo_cnt_nxt = 8'd0;
            end
          end else begin
            reg_wr_nxt     = mw_reg_wr & (mw_rd != 5'd0);
            write_add_nxt  = mw_rd;
            write_data_nxt = src_data;
          end
        end
      end
      WAIT_MEM: begin
        // Data arriving on the expiry cycle still completes the load.
        if (dmem_rvalid) begin
          reg_wr_nxt     = ld_reg_wr & (ld_rd != 5'd0);
          write_add_nxt  = ld_rd;
          write_data_nxt = ld_ext;
          state_nxt      = IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          load_err_nxt = 1'b1;
          state_nxt    = IDLE;
        end else begin
          tmo_cnt_nxt = tmo_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter and registered write-port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tmo_cnt    <= 8'd0;
      reg_wr     <= 1'b0;
      load_err   <= 1'b0;
      write_add  <= 5'd0;
      write_data <= '0;
    end else begin
      state      <= state_nxt;
      tmo_cnt    <= tmo_cnt_nxt;
      reg_wr     <= reg_wr_nxt;
      load_err   <= load_err_nxt;
      write_add  <= write_add_nxt;
      write_data <= write_data_nxt;
    end
  end

  // Capture the load's destination, type and byte offset when it is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_rd     <= 5'd0;
      ld_reg_wr <= 1'b0;
      ld_funct3 <= 3'd0;
      ld_off    <= 2'd0;
    end else if (accept && is_load) begin
      ld_rd     <= mw_rd;
      ld_reg_wr <= mw_reg_wr;
      ld_funct3 <= mw_ld_funct3;
      ld_off    <= mw_alu_result[1:0];
    end
  end

`ifdef WB_FWD_EN
  // Bypass mirrors the registered write port; while a load waits, expose its rd for stalling.
  always_comb begin
    fwd_valid = reg_wr & ~busy;
    fwd_rd    = busy ? ld_rd : write_add;
    fwd_data  = write_data;
  end
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = 5'd0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset, ALU/CSR/PC4 writeback, loads, misalignment, timeout, reset mid-load.
// Inputs change on negedge; outputs are sampled on the following negedge.
// DUT built with LOAD_TIMEOUT=4 so the timeout path is short.
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        mw_valid, mw_ready, mw_reg_wr;
  logic [4:0]  mw_rd;
  logic [1:0]  mw_wb_sel;
  logic [31:0] mw_alu_result, mw_pc4, mw_csr_rdata;
  logic [2:0]  mw_ld_funct3;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        reg_wr, load_err, busy, fwd_valid;
  logic [4:0]  write_add, fwd_rd;
  logic [31:0] write_data, fwd_data;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] rf [32];

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .LOAD_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .mw_valid(mw_valid), .mw_ready(mw_ready), .mw_reg_wr(mw_reg_wr),
    .mw_rd(mw_rd), .mw_wb_sel(mw_wb_sel), .mw_alu_result(mw_alu_result),
    .mw_pc4(mw_pc4), .mw_csr_rdata(mw_csr_rdata), .mw_ld_funct3(mw_ld_funct3),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .reg_wr(reg_wr), .write_add(write_add), .write_data(write_data),
    .load_err(load_err), .busy(busy),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  // Register file model writing on the falling edge.
  always @(negedge clk) if (reg_wr) rf[write_add] <= write_data;

  task automatic idle_inputs();
    mw_valid = 0; mw_reg_wr = 0; mw_rd = 0; mw_wb_sel = 0;
    mw_alu_result = 0; mw_pc4 = 0; mw_csr_rdata = 0; mw_ld_funct3 = 0;
    dmem_rvalid = 0; dmem_rdata = 0;
  endtask

  task automatic issue(input logic [1:0] sel, input logic [4:0] rd, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] csr);
    mw_valid = 1; mw_reg_wr = 1; mw_wb_sel = sel; mw_rd = rd; mw_ld_funct3 = f3;
    mw_alu_result = alu; mw_pc4 = pc4; mw_csr_rdata = csr;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    repeat (2) @(negedge clk);
    rst = 0;
    n_tests++; if (reg_wr !== 1'b0) begin n_fail++; $display("FAIL reset_reg_wr got %b exp 0", reg_wr); end
    n_tests++; if (write_add !== 5'd0) begin n_fail++; $display("FAIL reset_write_add got %0d exp 0", write_add); end
    n_tests++; if (write_data !== 32'h0) begin n_fail++; $display("FAIL reset_write_data got %h exp 0", write_data); end
    n_tests++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL reset_load_err got %b exp 0", load_err); end
    n_tests++; if (mw_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_ready_busy got %b%b exp 10", mw_ready, busy); end
    n_tests++; if ({fwd_valid, fwd_rd, fwd_data} !== 38'h0) begin n_fail++; $display("FAIL reset_fwd got %b %0d %h exp 0", fwd_valid, fwd_rd, fwd_data); end
  endtask

  task automatic test_alu();
    issue(2'd0, 5'd5, 3'd0, 32'h1234_5678, 32'h0, 32'h0);
    @(negedge clk); idle_inputs();
    n_tests++; if ({reg_wr, write_add, write_data} !== {1'b1, 5'd5, 32'h1234_5678}) begin n_fail++;
      $display("FAIL alu_wb got %b %0d %h exp 1 5 12345678", reg_wr, write_add, write_data); end
`ifdef WB_FWD_EN
    n_tests++; if ({fwd_valid, fwd_rd, fwd_data} !== {1'b1, 5'd5, 32'h1234_5678}) begin n_fail++;
      $display("FAIL alu_fwd got %b %0d %h exp 1 5 12345678", fwd_valid, fwd_rd, fwd_data); end
`else
    n_tests++; if ({fwd_valid, fwd_rd, fwd_data} !== 38'h0) begin n_fail++;
      $display("FAIL alu_fwd_off got %b %0d %h exp 0", fwd_valid, fwd_rd, fwd_data); end
`endif
    @(negedge clk); #1;
    n_tests++; if (reg_wr !== 1'b0 || write_data !== 32'h1234_5678) begin n_fail++;
      $display("FAIL alu_pulse_hold got %b %h exp 0 12345678", reg_wr, write_data); end
    n_tests++; if (rf[5] !== 32'h1234_5678) begin n_fail++; $display("FAIL alu_rf_x5 got %h exp 12345678", rf[5]); end
  endtask

  task automatic test_lb_sign();
    @(negedge clk);
    issue(2'd1, 5'd9, 3'b000, 32'h0000_0103, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle_inputs();
      if (i == 2) begin dmem_rvalid = 1; dmem_rdata = 32'h80FF_0000; end
      n_tests++; if ({busy, mw_ready, reg_wr} !== 3'b100) begin n_fail++;
        $display("FAIL lb_wait%0d busy/ready/reg_wr got %b%b%b exp 100", i, busy, mw_ready, reg_wr); end
`ifdef WB_FWD_EN
      n_tests++; if (fwd_valid !== 1'b0 || fwd_rd !== 5'd9) begin n_fail++;
        $display("FAIL lb_fwd_stall got %b %0d exp 0 9", fwd_valid, fwd_rd); end
`endif
    end
    @(negedge clk); idle_inputs();
    n_tests++; if ({reg_wr, write_add, write_data, busy} !== {1'b1, 5'd9, 32'hFFFF_FF80, 1'b0}) begin n_fail++;
      $display("FAIL lb_result got %b %0d %h busy %b exp 1 9 ffffff80 0", reg_wr, write_add, write_data, busy); end
    @(negedge clk);
    n_tests++; if (reg_wr !== 1'b0) begin n_fail++; $display("FAIL lb_pulse got %b exp 0", reg_wr); end
  endtask

  task automatic test_lh_rvalid_early();
    // rvalid already high at accept: ignored in IDLE, consumed on first WAIT_MEM cycle.
    issue(2'd1, 5'd10, 3'b001, 32'h0000_0202, 32'h0, 32'h0);
    dmem_rvalid = 1; dmem_rdata = 32'h8001_1234;
    @(negedge clk); mw_valid = 0;
    n_tests++; if (busy !== 1'b1 || reg_wr !== 1'b0) begin n_fail++;
      $display("FAIL lh_idle_ignore busy %b reg_wr %b exp 1 0", busy, reg_wr); end
    @(negedge clk); idle_inputs();
    n_tests++; if ({reg_wr, write_add, write_data} !== {1'b1, 5'd10, 32'hFFFF_8001}) begin n_fail++;
      $display("FAIL lh_result got %b %0d %h exp 1 10 ffff8001", reg_wr, write_add, write_data); end
    issue(2'd1, 5'd11, 3'b100, 32'h0000_0301, 32'h0, 32'h0);
    @(negedge clk); idle_inputs(); dmem_rvalid = 1; dmem_rdata = 32'h0000_F200;
    @(negedge clk); idle_inputs();
    n_tests++; if ({reg_wr, write_add, write_data} !== {1'b1, 5'd11, 32'h0000_00F2}) begin n_fail++;
      $display("FAIL lbu_result got %b %0d %h exp 1 11 000000f2", reg_wr, write_add, write_data); end
  endtask

  task automatic test_misaligned();
    issue(2'd1, 5'd4, 3'b010, 32'h0000_0102, 32'h0, 32'h0);
    @(negedge clk); idle_inputs();
    n_tests++; if ({load_err, reg_wr, mw_ready, busy} !== 4'b1010) begin n_fail++;
      $display("FAIL misaligned_lw err/wr/ready/busy got %b%b%b%b exp 1010", load_err, reg_wr, mw_ready, busy); end
    n_tests++; if (write_add !== 5'd11) begin n_fail++; $display("FAIL misaligned_hold_add got %0d exp 11", write_add); end
    @(negedge clk);
    n_tests++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL misaligned_pulse got %b exp 0", load_err); end
  endtask

  task automatic test_back_to_back();
    issue(2'd2, 5'd0, 3'd0, 32'h0, 32'h0000_0044, 32'h0);
    @(negedge clk);
    n_tests++; if ({reg_wr, write_add, write_data} !== {1'b0, 5'd0, 32'h0000_0044}) begin n_fail++;
      $display("FAIL x0_write got %b %0d %h exp 0 0 00000044", reg_wr, write_add, write_data); end
    issue(2'd3, 5'd7, 3'd0, 32'h0, 32'h0, 32'hDEAD_BEEF);
    @(negedge clk); idle_inputs();
    n_tests++; if ({reg_wr, write_add, write_data} !== {1'b1, 5'd7, 32'hDEAD_BEEF}) begin n_fail++;
      $display("FAIL b2b_csr got %b %0d %h exp 1 7 deadbeef", reg_wr, write_add, write_data); end
  endtask

  task automatic test_timeout();
    issue(2'd1, 5'd6, 3'b101, 32'h0000_0004, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle_inputs();
      n_tests++; if ({busy, load_err} !== 2'b10) begin n_fail++;
        $display("FAIL timeout_wait%0d busy/err got %b%b exp 10", i, busy, load_err); end
    end
    @(negedge clk);
    n_tests++; if ({load_err, reg_wr, busy, mw_ready} !== 4'b1001) begin n_fail++;
      $display("FAIL timeout_err err/wr/busy/ready got %b%b%b%b exp 1001", load_err, reg_wr, busy, mw_ready); end
    @(negedge clk);
    n_tests++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse got %b exp 0", load_err); end
  endtask

  task automatic test_expiry_rvalid();
    issue(2'd1, 5'd12, 3'b101, 32'h0000_0000, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle_inputs();
      if (i == 3) begin dmem_rvalid = 1; dmem_rdata = 32'h1111_9ABC; end
    end
    @(negedge clk); idle_inputs();
    n_tests++; if ({load_err, reg_wr, write_add, write_data} !== {1'b0, 1'b1, 5'd12, 32'h0000_9ABC}) begin n_fail++;
      $display("FAIL expiry_rvalid got err %b %b %0d %h exp 0 1 12 00009abc", load_err, reg_wr, write_add, write_data); end
  endtask

  task automatic test_reset_midload();
    issue(2'd1, 5'd3, 3'b101, 32'h0000_0002, 32'h0, 32'h0);
    @(negedge clk); idle_inputs();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midload_busy got %b exp 1", busy); end
    rst = 1;
    @(negedge clk); rst = 0; dmem_rvalid = 1; dmem_rdata = 32'hCAFE_0000;
    @(negedge clk); idle_inputs();
    n_tests++; if ({reg_wr, load_err, write_add, write_data} !== 39'h0) begin n_fail++;
      $display("FAIL midload_outputs got %b %b %0d %h exp 0 0 0 0", reg_wr, load_err, write_add, write_data); end
    n_tests++; if (mw_ready !== 1'b1 || busy !== 1'b0) begin n_fail++;
      $display("FAIL midload_ready got %b busy %b exp 1 0", mw_ready, busy); end
    n_tests++; if ({fwd_valid, fwd_rd, fwd_data} !== 38'h0) begin n_fail++;
      $display("FAIL midload_fwd got %b %0d %h exp 0", fwd_valid, fwd_rd, fwd_data); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lb_sign();
    test_lh_rvalid_early();
    test_misaligned();
    test_back_to_back();
    test_timeout();
    test_expiry_rvalid();
    test_reset_midload();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
